// File: rtl/char_ctrl_pkg.sv
// Shared types and constants for the character write controller.
package char_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_WAIT_SLOT,
    ST_WRITE,
    ST_RELEASE
  } state_e;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_PRINT,
    CLS_CR
  } char_class_e;

  localparam logic [6:0] CHAR_CR  = 7'h0D;
  localparam logic [6:0] PRINT_LO = 7'h20;
  localparam logic [6:0] PRINT_HI = 7'h7E;

  localparam int unsigned SLOT_TIMEOUT_DEF = 4096;

  // Decide which strobe a held code produces; a set bit 7 is never printable.
  function automatic char_class_e classify_char(input logic [7:0] code);
    char_class_e cls;
    cls = CLS_NONE;
    if (!code[7]) begin
      if (code[6:0] == CHAR_CR) begin
        cls = CLS_CR;
      end else if ((code[6:0] >= PRINT_LO) && (code[6:0] <= PRINT_HI)) begin
        cls = CLS_PRINT;
      end
    end
    return cls;
  endfunction

endpackage

// File: rtl/char_write_ctrl_if.sv
// Host-port and video-side signals of the character write controller.
interface char_write_ctrl_if;

  logic       da;
  logic [7:0] d;
  logic       cursor_slot;
  logic       clr_screen;
  logic       rda;
  logic [6:0] char_out;
  logic       wr_en;
  logic       cr_pulse;
  logic       drop_pulse;
  logic       busy;

  modport master (
    output da, d, cursor_slot, clr_screen,
    input  rda, char_out, wr_en, cr_pulse, drop_pulse, busy
  );

  modport slave (
    input  da, d, cursor_slot, clr_screen,
    output rda, char_out, wr_en, cr_pulse, drop_pulse, busy
  );

endinterface

// File: rtl/char_hold_reg.sv
// 8-bit character hold register with load enable and synchronous clear.
module char_hold_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       clr,
  input  logic [7:0] d,
  output logic [7:0] q
);

  logic [7:0] data_d;
  logic [7:0] data_q;

  // Clear wins over load.
  always_comb begin
    data_d = data_q;
    if (clr) begin
      data_d = 8'h00;
    end else if (load) begin
      data_d = d;
    end
  end

  // Hold storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= 8'h00;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/char_write_ctrl.sv
// Latches a host character and writes it into the cursor cell on the next cursor slot.
module char_write_ctrl
  import char_ctrl_pkg::*;
#(
  parameter int unsigned SLOT_TIMEOUT = SLOT_TIMEOUT_DEF,
  parameter bit          MASK_BIT7    = 1'b1
) (
  input  logic              cp,
  input  logic              mr,
  char_write_ctrl_if.slave  bus
);

  localparam int unsigned       TMR_W    = $clog2(SLOT_TIMEOUT + 1);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(SLOT_TIMEOUT - 1);

  state_e           state_d, state_q;
  logic             da_d, da_q;
  logic             arm_d, arm_q;
  logic [TMR_W-1:0] tmr_d, tmr_q;
  logic             rda_d, rda_q;
  logic             busy_d, busy_q;
  logic             wr_en_d, wr_en_q;
  logic             cr_d, cr_q;
  logic             drop_d, drop_q;
  logic             hold_load;
  logic             hold_clr;
  logic [7:0]       hold_din;
  logic [7:0]       hold_q;
  char_class_e      hold_cls;

  char_hold_reg u_hold (
    .clk  (cp),
    .rst  (mr),
    .load (hold_load),
    .clr  (hold_clr),
    .d    (hold_din),
    .q    (hold_q)
  );

  assign hold_cls = classify_char(hold_q);

  // Next state, slot timer, hold control and next-cycle strobes.
  // arm_q blocks a da that was already high out of reset from counting as an edge.
  always_comb begin
    state_d   = state_q;
    da_d      = bus.da;
    arm_d     = arm_q | ~bus.da;
    tmr_d     = tmr_q;
    wr_en_d   = 1'b0;
    cr_d      = 1'b0;
    drop_d    = 1'b0;
    hold_load = 1'b0;
    hold_clr  = 1'b0;
    hold_din  = bus.d;
    if (MASK_BIT7) begin
      hold_din[7] = 1'b0;
    end

    if (bus.clr_screen) begin
      state_d  = ST_IDLE;
      hold_clr = 1'b1;
      tmr_d    = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.da && !da_q && arm_q) begin
            state_d = ST_LATCH;
          end
        end
        ST_LATCH: begin
          hold_load = 1'b1;
          tmr_d     = '0;
          state_d   = ST_WAIT_SLOT;
        end
        ST_WAIT_SLOT: begin
          tmr_d = tmr_q + TMR_W'(1);
          if (bus.cursor_slot) begin
            state_d = ST_WRITE;
            wr_en_d = (hold_cls == CLS_PRINT);
            cr_d    = (hold_cls == CLS_CR);
          end else if (tmr_q == TMR_LAST) begin
            state_d = ST_RELEASE;
            drop_d  = 1'b1;
          end
        end
        ST_WRITE: begin
          state_d = ST_RELEASE;
        end
        ST_RELEASE: begin
          if (!bus.da) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    rda_d  = (state_d == ST_IDLE);
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge cp) begin
    if (mr) begin
      state_q <= ST_IDLE;
      da_q    <= 1'b0;
      arm_q   <= 1'b0;
      tmr_q   <= '0;
      rda_q   <= 1'b1;
      busy_q  <= 1'b0;
      wr_en_q <= 1'b0;
      cr_q    <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      da_q    <= da_d;
      arm_q   <= arm_d;
      tmr_q   <= tmr_d;
      rda_q   <= rda_d;
      busy_q  <= busy_d;
      wr_en_q <= wr_en_d;
      cr_q    <= cr_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.rda        = rda_q;
  assign bus.busy       = busy_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.cr_pulse   = cr_q;
  assign bus.drop_pulse = drop_q;
  assign bus.char_out   = hold_q[6:0];

endmodule

// File: tb/tb_char_write_ctrl.sv
// Randomized scoreboard bench for char_write_ctrl.
module tb_char_write_ctrl;

  localparam int TO = 16;

  localparam logic [2:0] K_WR   = 3'b100;
  localparam logic [2:0] K_CR   = 3'b010;
  localparam logic [2:0] K_DROP = 3'b001;

  typedef struct {
    logic [2:0] kind;
    logic [6:0] ch;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic mr;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_en = 1'b0;
  exp_t sb[$];

  char_write_ctrl_if bus ();

  char_write_ctrl #(.SLOT_TIMEOUT(TO), .MASK_BIT7(1'b1)) dut (
    .cp  (clk),
    .mr  (mr),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: which strobe a host byte should produce once its slot arrives.
  function automatic logic [2:0] ref_kind(input logic [7:0] dv);
    int code;
    code = int'(dv) % 128;
    if (code == 13) return K_CR;
    if (code >= 32 && code <= 126) return K_WR;
    return 3'b000;
  endfunction

  // Monitor: every strobe must match the oldest outstanding expectation.
  logic [2:0] mon_act;
  logic [2:0] mon_prev = 3'b000;
  exp_t       mon_e;
  always @(negedge clk) begin
    if (mon_en) begin
      mon_act = {bus.wr_en, bus.cr_pulse, bus.drop_pulse};
      if (mon_act != 3'b000) begin
        chk("strobe_onehot", 32'($countones(mon_act)), 32'd1);
        chk("strobe_back_to_back", 32'(mon_prev != 3'b000), 32'd0);
        if (sb.size() == 0) begin
          chk("strobe_unexpected", 32'(mon_act), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("strobe_kind", 32'(mon_act), 32'(mon_e.kind));
          chk("strobe_char", 32'(bus.char_out), 32'(mon_e.ch));
          chk("strobe_cycle", 32'(cyc), 32'(mon_e.cyc));
        end
      end
      mon_prev = mon_act;
    end
  end

  // One host character; k = slot offset from the da cycle (0 = none), c = clear offset (0 = none).
  task automatic run_txn(input logic [7:0] dv, input int k, input int c);
    int         n;
    int         t_end;
    logic [6:0] code;
    logic [2:0] kind;
    exp_t       e;
    n    = cyc;
    code = dv[6:0];
    kind = ref_kind(dv);
    bus.d  = dv;
    bus.da = 1'b1;
    if (c == 0) begin
      if (k >= 2 && k <= TO + 1) begin
        if (kind != 3'b000) begin
          e.kind = kind; e.ch = code; e.cyc = n + k + 1;
          sb.push_back(e);
        end
      end else begin
        e.kind = K_DROP; e.ch = code; e.cyc = n + TO + 2;
        sb.push_back(e);
      end
    end
    t_end = ((k > TO + 2) ? k : TO + 2) + $urandom_range(0, 3);
    for (int off = 1; off <= t_end; off++) begin
      @(negedge clk);
      bus.cursor_slot = (off == k);
      bus.clr_screen  = (c != 0) && (off == c);
      if (off == 2) begin
        chk("char_out_latched", 32'(bus.char_out), 32'(code));
        chk("busy_in_wait", 32'(bus.busy), 32'd1);
      end
      if (c != 0 && off == c + 1) begin
        chk("clr_rda", 32'(bus.rda), 32'd1);
        chk("clr_char_out", 32'(bus.char_out), 32'd0);
        chk("clr_busy", 32'(bus.busy), 32'd0);
      end
    end
    chk("rda_while_da_held", 32'(bus.rda), (c == 0) ? 32'd0 : 32'd1);
    @(negedge clk);
    bus.da          = 1'b0;
    bus.cursor_slot = 1'b0;
    bus.clr_screen  = 1'b0;
    @(negedge clk);
    chk("rda_after_da_low", 32'(bus.rda), 32'd1);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  logic [7:0] rdv;
  int         rk;
  int         rc;
  int         sel;

  initial begin
    mr = 1'b1;
    bus.da = 1'b1;
    bus.d = 8'h41;
    bus.cursor_slot = 1'b0;
    bus.clr_screen = 1'b0;

    // Reset held two cycles with da already high.
    @(negedge clk);
    mon_en = 1'b1;
    chk("rst_rda_during", 32'(bus.rda), 32'd1);
    @(negedge clk);
    mr = 1'b0;
    chk("rst_rda", 32'(bus.rda), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_char_out", 32'(bus.char_out), 32'd0);
    repeat (6) @(negedge clk);
    chk("rst_no_latch_rda", 32'(bus.rda), 32'd1);
    chk("rst_no_latch_busy", 32'(bus.busy), 32'd0);
    bus.da = 1'b0;
    repeat (2) @(negedge clk);

    // Directed cases.
    run_txn(8'hC1, 5, 0);
    run_txn(8'h8D, 4, 0);
    run_txn(8'h07, 3, 0);
    run_txn(8'h5A, 0, 0);
    run_txn(8'h33, TO + 1, 0);
    run_txn(8'h42, 9, 4);
    run_txn(8'h7E, 1, 0);
    run_txn(8'h7F, 2, 0);
    run_txn(8'h20, TO + 2, 0);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      rdv = 8'($urandom);
      if ($urandom_range(0, 5) == 0) rdv[6:0] = 7'h0D;
      sel = $urandom_range(0, 9);
      rc  = 0;
      case (sel)
        0: rk = 0;
        1: rk = TO + 1;
        2: rk = 1;
        3: rk = $urandom_range(TO + 2, TO + 4);
        4: begin
          rk = $urandom_range(4, TO + 1);
          rc = $urandom_range(2, rk - 1);
        end
        default: rk = $urandom_range(2, TO);
      endcase
      run_txn(rdv, rk, rc);
    end

    // Reset in the middle of WAIT_SLOT abandons the character.
    bus.d  = 8'h55;
    bus.da = 1'b1;
    repeat (4) @(negedge clk);
    mr = 1'b1;
    @(negedge clk);
    mr = 1'b0;
    @(negedge clk);
    bus.cursor_slot = 1'b1;
    @(negedge clk);
    bus.cursor_slot = 1'b0;
    chk("midrst_rda", 32'(bus.rda), 32'd1);
    chk("midrst_char_out", 32'(bus.char_out), 32'd0);
    repeat (4) @(negedge clk);
    chk("midrst_no_relatch", 32'(bus.busy), 32'd0);
    bus.da = 1'b0;
    repeat (3) @(negedge clk);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
